// File: rtl/prog_loader.sv
// Byte-stream program loader: writes a length-prefixed frame into instruction memory and holds/releases the CPU.
// Optional trailing XOR checksum byte and CHK/ERR path enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              cpu_pc_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [DATA_W:0]   words_written
);

  localparam int unsigned      CNT_W     = DATA_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              pc_rst_q, pc_rst_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              accept;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign accept = in_valid && ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    pc_rst_d = 1'b0;
    done_d   = done_q;
    words_d  = words_q;
    len_d    = len_q;
    idx_d    = idx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    err_d    = err_q;
    csum_d   = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          words_d = '0;
          idx_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
          csum_d  = '0;
`endif
        end
      end

      S_LEN: begin
        if (accept) begin
          // A zero length byte encodes a full 2^DATA_W word program
          len_d   = (in_data == '0) ? MAX_WORDS : CNT_W'(in_data);
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
          wdata_d = in_data;
          idx_d   = idx_q + CNT_W'(1);
          if (words_q != MAX_WORDS) begin
            words_d = words_q + CNT_W'(1);
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
          if (idx_q + CNT_W'(1) == len_q) begin
            state_d = S_CHK;
          end
`else
          if (idx_q + CNT_W'(1) == len_q) begin
            state_d  = S_DONE;
            hold_d   = 1'b0;
            done_d   = 1'b1;
            pc_rst_d = 1'b1;
          end
`endif
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d  = S_DONE;
            hold_d   = 1'b0;
            done_d   = 1'b1;
            pc_rst_d = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      wdata_q  <= '0;
      hold_q   <= HOLD_ON_RESET;
      pc_rst_q <= 1'b0;
      done_q   <= 1'b0;
      words_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      pc_rst_q <= pc_rst_d;
      done_q   <= done_d;
      words_q  <= words_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      csum_q <= '0;
    end else begin
      err_q  <= err_d;
      csum_q <= csum_d;
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign in_ready      = ready_q;
  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_hold      = hold_q;
  assign cpu_pc_rst    = pc_rst_q;
  assign load_done     = done_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader; reference model derives writes and status from the frame contents.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BASE   = 32'hF0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              cpu_pc_rst;
  logic              load_done;
  logic              load_err;
  logic [DATA_W:0]   words_written;

  prog_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BASE_ADDR(BASE),
    .HOLD_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .cpu_pc_rst(cpu_pc_rst),
    .load_done(load_done),
    .load_err(load_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] frame[$];
  logic [7:0] mem_exp[256];
  logic [7:0] mem_obs[256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Shadow of what the DUT actually wrote to instruction memory
  always @(negedge clk) begin
    if (imem_we) mem_obs[imem_addr] <= imem_wdata;
  end

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_ready"}, 32'(in_ready), 32'd0);
    check_eq({pfx, "_we"},    32'(imem_we), 32'd0);
    check_eq({pfx, "_addr"},  32'(imem_addr), BASE);
    check_eq({pfx, "_wdata"}, 32'(imem_wdata), 32'd0);
    check_eq({pfx, "_hold"},  32'(cpu_hold), 32'd1);
    check_eq({pfx, "_pcrst"}, 32'(cpu_pc_rst), 32'd0);
    check_eq({pfx, "_done"},  32'(load_done), 32'd0);
    check_eq({pfx, "_err"},   32'(load_err), 32'd0);
    check_eq({pfx, "_words"}, 32'(words_written), 32'd0);
  endtask

  // Random frame of len_byte words; optional checksum byte, optionally corrupted
  task automatic build_random(input int len_byte, input bit corrupt);
    int n;
    logic [7:0] b;
    logic [7:0] sum;
    frame.delete();
    frame.push_back(8'(len_byte));
    n = (len_byte == 0) ? 256 : len_byte;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      sum = sum ^ b;
      frame.push_back(b);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    frame.push_back(corrupt ? (sum ^ 8'($urandom_range(1, 255))) : sum);
`else
    if (corrupt) frame.push_back(sum);
`endif
  endtask

  // Drives one frame, checking every write; abort_at >= 0 stops after that byte index is accepted
  task automatic send_frame(input bit stall, input int abort_at, input bit exp_ok);
    int n;
    int len;
    int budget;
    bit acc;
    bit v;
    n = frame.size();
    len = (frame[0] == 8'h00) ? 256 : int'(frame[0]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        start = stall && ($urandom_range(0, 5) == 0);
        in_valid = v;
        in_data = v ? frame[k] : 8'($urandom);
        check_eq("hold_busy", 32'(cpu_hold), 32'd1);
        acc = v && in_ready;
        @(negedge clk);
        if (acc && k >= 1 && k <= len) begin
          check_eq("we", 32'(imem_we), 32'd1);
          check_eq("waddr", 32'(imem_addr), (BASE + 32'(k) - 32'd1) % 32'd256);
          check_eq("wdata", 32'(imem_wdata), 32'(frame[k]));
          mem_exp[(BASE + 32'(k) - 32'd1) % 32'd256] = frame[k];
        end else begin
          check_eq("we_idle", 32'(imem_we), 32'd0);
        end
        if (!acc) begin
          budget++;
          if (budget > 40) begin
            check_eq("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            start = 1'b0;
            return;
          end
        end
      end
      if (k == abort_at) begin
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    check_eq("ready_end", 32'(in_ready), 32'd0);
    check_eq("words", 32'(words_written), 32'(len));
    check_eq("pcrst_first", 32'(cpu_pc_rst), 32'(exp_ok));
    check_eq("hold_end", 32'(cpu_hold), 32'(!exp_ok));
    check_eq("done", 32'(load_done), 32'(exp_ok));
    check_eq("err", 32'(load_err), 32'(!exp_ok));
    @(negedge clk);
    check_eq("pcrst_second", 32'(cpu_pc_rst), 32'd0);
    check_eq("we_after", 32'(imem_we), 32'd0);
    check_eq("hold_after", 32'(cpu_hold), 32'(!exp_ok));
    check_eq("done_after", 32'(load_done), 32'(exp_ok));
    check_eq("err_after", 32'(load_err), 32'(!exp_ok));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int len;
    bit corrupt;
    for (int i = 0; i < 256; i++) mem_exp[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_ready", 32'(in_ready), 32'd0);
    check_eq("idle_hold", 32'(cpu_hold), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    frame = {8'h03, 8'h12, 8'h34, 8'h56, 8'h70};
    send_frame(1'b0, -1, 1'b1);
    frame[4] = 8'h71;
    send_frame(1'b0, -1, 1'b0);
    frame[4] = 8'h70;
    send_frame(1'b0, -1, 1'b1);
    send_frame(1'b1, -1, 1'b1);
`else
    frame = {8'h02, 8'hAA, 8'hBB};
    send_frame(1'b0, -1, 1'b1);
    send_frame(1'b1, -1, 1'b1);
`endif

    // Full-length frame wraps past the top of memory
    build_random(0, 1'b0);
    send_frame(1'b0, -1, 1'b1);

    for (int f = 0; f < 6; f++) begin
      len = int'($urandom_range(1, 40));
`ifdef PROG_LOADER_CHECKSUM_EN
      corrupt = ($urandom_range(0, 3) == 0);
`else
      corrupt = 1'b0;
`endif
      build_random(len, corrupt);
      send_frame(1'($urandom_range(0, 1)), -1, !corrupt);
    end

    // Asynchronous reset between clock edges in the middle of the data phase
    build_random(10, 1'b0);
    send_frame(1'b0, 4, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset_values("async");
    @(negedge clk);
    rst = 1'b0;
    build_random(5, 1'b0);
    send_frame(1'b1, -1, 1'b1);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      check_eq("mem", 32'(mem_obs[i]), 32'(mem_exp[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the writer side of the CPU's instruction memory, which the CPU only ever reads.
- Accepts a framed program over a valid/ready byte interface and writes it into instruction memory at consecutive addresses.
- Holds the CPU during load and releases it with a one-cycle PC-reset pulse on success.
- Sits between a host/UART byte source and the instruction memory write port, beside cpu_top.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DATA_W, 8, instruction word / stream byte width.
- BASE_ADDR, 0, first instruction memory address written.
- HOLD_ON_RESET, 1, reset value of cpu_hold.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  DATA_W  write data.
- cpu_hold  output  1  stall CPU (PC and register writes frozen).
- cpu_pc_rst  output  1  one-cycle pulse forcing CPU PC to 0.
- load_done  output  1  level, last load succeeded.
- load_err  output  1  level, last load failed checksum.
- words_written  output  DATA_W+1  data words written in current/last load.

Behaviour:
- Reset (async): state IDLE; in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=HOLD_ON_RESET, cpu_pc_rst=0, load_done=0, load_err=0, words_written=0. Reset mid-load abandons the frame; partially written memory is not restored.
- States: IDLE, LEN, DATA, CHK, DONE, ERR. All outputs are registered.
- Handshake: a byte is accepted when in_valid && in_ready. in_ready=1 only in LEN, DATA and CHK. in_valid may stall arbitrarily with no timeout.
- IDLE/DONE/ERR + start: go to LEN; cpu_hold=1; clear load_done, load_err, words_written and checksum. start in LEN/DATA/CHK is ignored.
- LEN + accept: store length L = in_data; L=0 means 2^DATA_W words. Go to DATA.
- DATA + accept, write path: one cycle later imem_we=1, imem_addr=BASE_ADDR+index (mod 2^ADDR_W), imem_wdata=byte.
- DATA + accept, bookkeeping: index and words_written increment; checksum ^= byte.
- DATA exit: after the L-th accepted word, go to CHK. Latency from accept to write is exactly 1 cycle; back-to-back accepts give back-to-back writes.
- CHK + accept: if byte == running XOR, go to DONE; otherwise go to ERR.
- DONE entry: cpu_hold=0, load_done=1, and cpu_pc_rst=1 for exactly one cycle, coincident with the first cycle of cpu_hold=0.
- ERR: cpu_hold stays 1 and load_err=1 until the next start or rst.
- Address wrap: when L exceeds 2^ADDR_W, the address wraps to 0 and overwrites earlier words. This is legal, not an error.
- words_written saturates at 2^DATA_W.
- The last data write (imem_we) completes before, or in the same cycle as, the CHK state is entered. No imem_we in CHK/DONE/ERR.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: the CHK state and checksum byte are present as described above.
- Undefined: no checksum byte in the frame and no CHK state. DATA goes directly to DONE after the L-th word; load_err is tied to 0 and ERR is unreachable.

Test Plan:
- Reset with HOLD_ON_RESET=1 -> cpu_hold=1, in_ready=0, load_done=0, imem_we=0.
- Nominal load: start; stream 0x03,0x12,0x34,0x56,0x70 with in_valid held high -> writes addr 0..2 = 0x12,0x34,0x56 on consecutive cycles. Then load_done=1, cpu_hold=0, single cpu_pc_rst pulse, words_written=3.
- Bad checksum: same frame with final byte 0x71 -> ERR; load_err=1, cpu_hold stays 1, no cpu_pc_rst. A following start plus a correct frame -> DONE.
- Stalled source: same nominal frame with in_valid toggling 1-0-0-1 -> identical memory contents; imem_we only follows accepted bytes; start pulses mid-frame are ignored.
- Length 0 with BASE_ADDR=0xF0 -> 256 writes, addresses wrap 0xF0..0xFF,0x00..0xEF; words_written=256.
- Reset asserted asynchronously mid-DATA (between clock edges) -> outputs take reset values immediately. A new start plus a full frame then loads correctly.
- Without PROG_LOADER_CHECKSUM_EN: frame 0x02,0xAA,0xBB -> DONE immediately after 0xBB is written; load_err never asserts.
